// File: rtl/interp_pkg.sv
// rtl/interp_pkg.sv - shared state encoding, default sizes and width helpers for interp_mac_sched
package interp_pkg;

  localparam int NTAP_DEF = 25;
  localparam int L_DEF    = 4;
  localparam int AW_DEF   = 8;
  localparam int CW_DEF   = 8;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    MAC,
    DRAIN,
    OUT
  } state_t;

  // Minimum 1 bit so single-valued counters still get a legal vector.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int TAP_W_DEF = cnt_w(NTAP_DEF + 1);
  localparam int PH_W_DEF  = cnt_w(L_DEF);

endpackage

// File: rtl/interp_strobe_dly.sv
// rtl/interp_strobe_dly.sv - aligns MAC issue strobes with the sample RAM / coefficient ROM read data
module interp_strobe_dly #(
  parameter int LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic issue_en,
  input  logic issue_clr,
  input  logic issue_last,
  output logic mac_en,
  output logic mac_clr,
  output logic mac_last
);

  logic [2:0] pipe [LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) begin
        pipe[i] <= '0;
      end
    end else begin
      pipe[0] <= {issue_en, issue_clr, issue_last};
      for (int i = 1; i < LAT; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign {mac_en, mac_clr, mac_last} = pipe[LAT-1];

endmodule

// File: rtl/interp_mac_sched.sv
// rtl/interp_mac_sched.sv - handshake-driven sequencer for the polyphase interpolation MAC datapath
module interp_mac_sched
  import interp_pkg::*;
#(
  parameter int NTAP = NTAP_DEF,
  parameter int L    = L_DEF,
  parameter int AW   = AW_DEF,
  parameter int CW   = CW_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                s_valid,
  output logic                s_ready,
  output logic                wr_en,
  output logic [AW-1:0]       wr_addr,
  output logic [AW-1:0]       rd_addr,
  output logic                rd_zero,
  output logic [CW-1:0]       coef_addr,
  output logic                mac_clr,
  output logic                mac_en,
  output logic                mac_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [cnt_w(L)-1:0] phase,
  output logic                busy
);

  localparam int TW = cnt_w(NTAP + 1);
  localparam int PW = cnt_w(L);

  state_t        state, nxt_state;
  logic [AW-1:0] wr_ptr, nxt_wr_ptr;
  logic [AW-1:0] base, nxt_base;
  logic [TW-1:0] fill, nxt_fill;
  logic [TW-1:0] tap, nxt_tap;
  logic [PW-1:0] nxt_phase;
  logic [CW-1:0] nxt_coef;
  logic          issue_en, issue_clr, issue_last;
  logic          mac_issue;

  always_comb begin
    nxt_state  = state;
    nxt_wr_ptr = wr_ptr;
    nxt_base   = base;
    nxt_fill   = fill;
    nxt_tap    = tap;
    nxt_phase  = phase;
    nxt_coef   = coef_addr;
    case (state)
      IDLE: begin
        if (s_valid && s_ready) begin
          nxt_state = WRITE;
        end
      end
      WRITE: begin
        nxt_base   = wr_ptr;
        nxt_wr_ptr = wr_ptr + AW'(1);
        nxt_fill   = (fill == TW'(NTAP)) ? fill : fill + TW'(1);
        nxt_phase  = '0;
        nxt_tap    = '0;
        nxt_coef   = '0;
        nxt_state  = MAC;
      end
      MAC: begin
        if (tap == TW'(NTAP - 1)) begin
          nxt_state = DRAIN;
        end else begin
          nxt_tap  = tap + TW'(1);
          nxt_coef = coef_addr + CW'(1);
        end
      end
      DRAIN: begin
        nxt_state = OUT;
      end
      OUT: begin
        if (out_ready) begin
          if (phase == PW'(L - 1)) begin
            nxt_state = IDLE;
          end else begin
            // coef_addr continues from the last tap, giving (phase+1)*NTAP without a multiplier
            nxt_phase = phase + PW'(1);
            nxt_tap   = '0;
            nxt_coef  = coef_addr + CW'(1);
            nxt_state = MAC;
          end
        end
      end
      default: begin
        nxt_state = IDLE;
      end
    endcase
  end

  assign mac_issue = (nxt_state == MAC);

  // Outputs are registered from next-state values so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      base       <= '0;
      fill       <= '0;
      tap        <= '0;
      phase      <= '0;
      coef_addr  <= '0;
      s_ready    <= 1'b1;
      busy       <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      rd_addr    <= '0;
      rd_zero    <= 1'b0;
      out_valid  <= 1'b0;
      issue_en   <= 1'b0;
      issue_clr  <= 1'b0;
      issue_last <= 1'b0;
    end else begin
      state      <= nxt_state;
      wr_ptr     <= nxt_wr_ptr;
      base       <= nxt_base;
      fill       <= nxt_fill;
      tap        <= nxt_tap;
      phase      <= nxt_phase;
      coef_addr  <= nxt_coef;
      s_ready    <= (nxt_state == IDLE);
      busy       <= (nxt_state != IDLE);
      wr_en      <= (nxt_state == WRITE);
      wr_addr    <= wr_ptr;
      rd_addr    <= nxt_base - AW'(nxt_tap);
      rd_zero    <= mac_issue && (nxt_tap >= nxt_fill);
      out_valid  <= (nxt_state == OUT);
      issue_en   <= mac_issue;
      issue_clr  <= mac_issue && (nxt_tap == '0);
      issue_last <= mac_issue && (nxt_tap == TW'(NTAP - 1));
    end
  end

  interp_strobe_dly #(
    .LAT(1)
  ) u_strobe_dly (
    .clk        (clk),
    .rst_n      (rst_n),
    .issue_en   (issue_en),
    .issue_clr  (issue_clr),
    .issue_last (issue_last),
    .mac_en     (mac_en),
    .mac_clr    (mac_clr),
    .mac_last   (mac_last)
  );

endmodule

// File: tb/tb_interp_mac_sched.sv
// tb/tb_interp_mac_sched.sv - scoreboard bench for interp_mac_sched
module tb_interp_mac_sched;

  localparam int NTAP = 25;
  localparam int L    = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       s_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic       s_ready, wr_en, rd_zero, mac_clr, mac_en, mac_last, out_valid, busy;
  logic [7:0] wr_addr, rd_addr, coef_addr;
  logic [1:0] phase;

  interp_mac_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .rd_addr   (rd_addr),
    .rd_zero   (rd_zero),
    .coef_addr (coef_addr),
    .mac_clr   (mac_clr),
    .mac_en    (mac_en),
    .mac_last  (mac_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .phase     (phase),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ph;
    int base;
    int fill;
    int lat;
  } item_t;

  item_t q[$];
  int    wq[$];
  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  int    bwr = 0;
  int    bfill = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: samples on the falling edge, pops the scoreboard on every DUT event
  item_t      it;
  int         tidx = 0;
  int         s_hs = 0;
  int         last_hs = 0;
  int         wexp;
  logic       prev_ov = 1'b0;
  logic       prev_hs = 1'b0;
  logic [1:0] prev_phase = '0;
  logic [7:0] p_rd = '0;
  logic [7:0] p_coef = '0;
  logic       p_zero = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      tidx    = 0;
      prev_ov = 1'b0;
      prev_hs = 1'b0;
    end else begin
      if (wr_en) begin
        if (wq.size() == 0) begin
          chk("wr_unexpected", 1, 0);
        end else begin
          wexp = wq.pop_front();
          chk("wr_addr", wr_addr, wexp);
          chk("wr_latency", cyc - s_hs, 1);
        end
      end
      if (mac_en) begin
        if (q.size() == 0) begin
          chk("mac_unexpected", 1, 0);
        end else begin
          it = q[0];
          chk("mac_clr", mac_clr, tidx == 0);
          chk("mac_last", mac_last, tidx == NTAP - 1);
          chk("rd_addr", p_rd, (it.base - tidx) & 255);
          chk("rd_zero", p_zero, tidx >= it.fill);
          chk("coef_addr", p_coef, it.ph * NTAP + tidx);
          tidx++;
        end
      end
      if (prev_ov && !prev_hs) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_phase", phase, prev_phase);
        chk("stall_mac_en", mac_en, 0);
        chk("stall_s_ready", s_ready, 0);
      end
      if (out_valid && !prev_ov) begin
        if (q.size() == 0) chk("out_unexpected", 1, 0);
        else chk("out_latency", cyc - last_hs, q[0].lat);
      end
      if (out_valid && out_ready) begin
        if (q.size() != 0) begin
          it = q.pop_front();
          chk("out_phase", phase, it.ph);
          chk("tap_count", tidx, NTAP);
        end
        tidx    = 0;
        last_hs = cyc;
      end
      if (s_valid && s_ready) begin
        s_hs    = cyc;
        last_hs = cyc;
      end
      prev_ov    = out_valid;
      prev_hs    = out_valid && out_ready;
      prev_phase = phase;
      p_rd       = rd_addr;
      p_coef     = coef_addr;
      p_zero     = rd_zero;
    end
  end

  task automatic check_rst_outputs();
    chk("rst_s_ready", s_ready, 1);
    chk("rst_strobes", {wr_en, rd_zero, mac_clr, mac_en, mac_last, out_valid, busy}, 0);
    chk("rst_buses", {wr_addr, rd_addr, coef_addr, phase}, 0);
  endtask

  task automatic send();
    item_t e;
    int n = 0;
    while (!s_ready && n < 500) begin
      @(posedge clk); #2;
      n++;
    end
    if (!s_ready) chk("send_timeout", 0, 1);
    s_valid = 1'b1;
    wq.push_back(bwr);
    bfill = (bfill < NTAP) ? bfill + 1 : NTAP;
    for (int p = 0; p < L; p++) begin
      e.ph   = p;
      e.base = bwr;
      e.fill = bfill;
      e.lat  = (p == 0) ? NTAP + 3 : NTAP + 2;
      q.push_back(e);
    end
    bwr = (bwr + 1) % 256;
    @(posedge clk); #2;
    s_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while ((q.size() != 0 || wq.size() != 0 || busy) && n < budget) begin
      @(posedge clk); #2;
      n++;
    end
    chk("done_timeout", (q.size() == 0 && wq.size() == 0 && !busy), 1);
  endtask

  task automatic wait_phase(input int p, input int budget);
    int n = 0;
    while (!(busy && phase == 2'(p)) && n < budget) begin
      @(posedge clk); #2;
      n++;
    end
    chk("phase_timeout", (busy && phase == 2'(p)), 1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2;
    check_rst_outputs();
    rst_n = 1'b1;
    @(posedge clk); #2;

    send();
    wait_done(300);
    chk("idle_s_ready", s_ready, 1);

    send();
    wait_phase(1, 300);
    out_ready = 1'b0;
    for (int n = 0; n < 100 && !out_valid; n++) begin
      @(posedge clk); #2;
    end
    chk("stall_reached", out_valid, 1);
    repeat (10) @(posedge clk);
    #2;
    out_ready = 1'b1;
    wait_done(300);

    for (int i = 2; i < 260; i++) begin
      send();
      wait_done(300);
    end

    send();
    wait_phase(2, 300);
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_rst_outputs();
    q.delete();
    wq.delete();
    bwr   = 0;
    bfill = 0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #2;
    chk("post_rst_s_ready", s_ready, 1);
    send();
    wait_done(300);

    chk("sb_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not complete (total=%0d bad=%0d)", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
